// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM encoding and step-count helper for the multi-cycle ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_FWD      = 3'b000;
  localparam logic [2:0] OP_ADD      = 3'b001;
  localparam logic [2:0] OP_AND      = 3'b010;
  localparam logic [2:0] OP_OR       = 3'b011;
  localparam logic [2:0] OP_SHIFT_LR = 3'b100;
  localparam logic [2:0] OP_SRA      = 3'b101;
  localparam logic [2:0] OP_ROR      = 3'b110;
  localparam logic [2:0] OP_MUL      = 3'b111;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // Number of engine steps after the accept edge; 0 means the op finishes on the accept edge.
  function automatic int unsigned step_count(input logic [2:0] op, input logic [31:0] b,
                                             input int unsigned width);
    logic [31:0] mask;
    logic [31:0] c;
    mask = (32'd1 << (width - 1)) - 32'd1;
    c = 32'd0;
    step_count = 0;
    case (op)
      OP_SHIFT_LR: begin
        c = b & mask;
        step_count = (c >= width) ? width : c;
      end
      OP_SRA: begin
        c = b;
        step_count = (c >= width) ? width : c;
      end
      OP_ROR:  step_count = b % width;
      OP_MUL:  step_count = width;
      default: step_count = 0;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-position shift/rotate; dir 0 = left, 1 = right.
module alu_shift_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  logic             fill,
  input  logic             rot,
  output logic [WIDTH-1:0] result
);

  logic in_bit;

  always_comb begin
    in_bit = fill;
    result = value;
    if (dir) begin
      in_bit = rot ? value[0] : fill;
      result = {in_bit, value[WIDTH-1:1]};
    end else begin
      in_bit = rot ? value[WIDTH-1] : fill;
      result = {value[WIDTH-2:0], in_bit};
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with START/BUSY/DONE handshake and iterative shift/rotate/multiply engine.
// Optional high product half on RESULT_HI when ALU_SEQ_MULHI_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
`ifdef ALU_SEQ_MULHI_EN
  ,
  output logic [WIDTH-1:0] RESULT_HI
`endif
);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opr_q, opr_d;      // value being shifted, or multiplier for MUL
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic             sh_dir, sh_fill, sh_rot;
  logic [WIDTH-1:0] sh_out;
  logic [WIDTH-1:0] single_res;
  int unsigned      steps;

  // MUL: add multiplicand into the high half, then shift {sum, multiplier} right by one.
  assign sum = {1'b0, acc_q} + (opr_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    sh_dir  = dir_q;
    sh_fill = 1'b0;
    sh_rot  = 1'b0;
    case (op_q)
      OP_SRA: begin
        sh_dir  = 1'b1;
        sh_fill = opr_q[WIDTH-1];
      end
      OP_ROR: begin
        sh_dir = 1'b1;
        sh_rot = 1'b1;
      end
      OP_MUL: begin
        sh_dir  = 1'b1;
        sh_fill = sum[0];
      end
      default: ;
    endcase
  end

  alu_shift_step #(
    .WIDTH(WIDTH)
  ) u_shift (
    .value (opr_q),
    .dir   (sh_dir),
    .fill  (sh_fill),
    .rot   (sh_rot),
    .result(sh_out)
  );

  assign steps = step_count(SELECT, 32'(DATA2), WIDTH);

  // Zero-count shifts/rotates fall through to DATA1 unchanged.
  always_comb begin
    case (SELECT)
      OP_FWD:  single_res = DATA2;
      OP_ADD:  single_res = DATA1 + DATA2;
      OP_AND:  single_res = DATA1 & DATA2;
      OP_OR:   single_res = DATA1 | DATA2;
      default: single_res = DATA1;
    endcase
  end

`ifdef ALU_SEQ_MULHI_EN
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] fin_hi;
  assign fin_hi    = (op_q == OP_MUL) ? sum[WIDTH:1] : '0;
  assign RESULT_HI = hi_q;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opr_d    = opr_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
`ifdef ALU_SEQ_MULHI_EN
    hi_d     = hi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d = SELECT;
          if (steps == 0) begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            done_d   = 1'b1;
`ifdef ALU_SEQ_MULHI_EN
            hi_d     = '0;
`endif
          end else begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(steps);
            opr_d   = (SELECT == OP_MUL) ? DATA2 : DATA1;
            mcand_d = DATA1;
            acc_d   = '0;
            dir_d   = (SELECT == OP_SHIFT_LR) ? DATA2[WIDTH-1] : 1'b1;
          end
        end
      end
      S_RUN: begin
        opr_d = sh_out;
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) acc_d = sum[WIDTH:1];
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = sh_out;
`ifdef ALU_SEQ_MULHI_EN
          hi_d     = fin_hi;
          zero_d   = (sh_out == '0) && (fin_hi == '0);
`else
          zero_d   = (sh_out == '0);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      op_q     <= OP_FWD;
      opr_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_MULHI_EN
      hi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opr_q    <= opr_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
`ifdef ALU_SEQ_MULHI_EN
      hi_q     <= hi_d;
`endif
    end
  end

  assign RESULT = result_q;
  assign ZERO   = zero_q;
  assign BUSY   = (state_q == S_RUN);
  assign DONE   = done_q;

endmodule
